// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO hub: address regions, I/O word map,
// output-register write modes and KEYSTAT bit layout.
package mmio_pkg;

    typedef enum logic [1:0] {
        REG_NONE = 2'b00,
        REG_DMEM = 2'b01,
        REG_SMEM = 2'b10,
        REG_IO   = 2'b11
    } region_t;

    localparam int unsigned IO_KEYDATA  = 0;
    localparam int unsigned IO_KEYSTAT  = 1;
    localparam int unsigned IO_IN_BASE  = 2;
    localparam int unsigned IO_OUT_BASE = 16;

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        SET  = 2'b01,
        CLR  = 2'b10,
        TGL  = 2'b11
    } wmode_t;

    localparam int KS_EMPTY   = 0;
    localparam int KS_FULL    = 1;
    localparam int KS_OVF     = 2;
    localparam int KS_CNT_LSB = 8;

    // Read-modify-write combine used by every output register write.
    function automatic logic [31:0] apply_mode(wmode_t m, logic [31:0] cur, logic [31:0] d);
        logic [31:0] r;
        case (m)
            LOAD:    r = d;
            SET:     r = cur | d;
            CLR:     r = cur & ~d;
            default: r = cur ^ d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem.sv
// Data memory: synchronous write, combinational read, word addressed.
module dmem #(
    parameter int Nloc  = 64,
    parameter int Dbits = 32
) (
    input  logic                     clk,
    input  logic                     wr,
    input  logic [$clog2(Nloc)-1:0]  addr,
    input  logic [Dbits-1:0]         din,
    output logic [Dbits-1:0]         dout
);
    logic [Dbits-1:0] mem [Nloc];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr && int'(addr) < Nloc) mem[addr] <= din;
    end

    assign dout = (int'(addr) < Nloc) ? mem[addr] : '0;

endmodule

// File: rtl/key_fifo.sv
// Keyboard character FIFO with status flags and a sticky overflow bit.
// A push into a full queue survives only if a pop lands in the same cycle.
module key_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [7:0]              data_i,
    input  logic                    pop_i,
    input  logic                    ovf_clr_i,
    output logic [7:0]              head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    ovf_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          do_pop, do_push, drop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop    = push_i && full_o && !do_pop;

    // Pointers, occupancy and overflow; a new drop outranks a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: ;
            endcase
            if (drop)           ovf_q <= 1'b1;
            else if (ovf_clr_i) ovf_q <= 1'b0;
        end
    end

    // Character storage, not reset: stale entries are masked by the count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign head_o  = empty_o ? 8'h00 : mem_q[rptr_q];
    assign count_o = cnt_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/screenmem.sv
// Screen memory: CPU read/write port plus an independent VGA read port.
module screenmem #(
    parameter int Nloc  = 1200,
    parameter int Dbits = 4,
    parameter int VA    = 11
) (
    input  logic                     clk,
    input  logic                     wr,
    input  logic [$clog2(Nloc)-1:0]  addr,
    input  logic [Dbits-1:0]         din,
    output logic [Dbits-1:0]         dout,
    input  logic [VA-1:0]            vaddr,
    output logic [Dbits-1:0]         vdout
);
    logic [Dbits-1:0] mem [Nloc];

    // CPU write port.
    always_ff @(posedge clk) begin
        if (wr && int'(addr) < Nloc) mem[addr] <= din;
    end

    assign dout  = (int'(addr)  < Nloc) ? mem[addr]  : '0;
    assign vdout = (int'(vaddr) < Nloc) ? mem[vaddr] : '0;

endmodule

// File: rtl/mmio_hub.sv
// CPU data-port hub: decodes the address into dmem, smem or I/O space,
// owns the output registers and the keyboard FIFO, and muxes read data.
module mmio_hub
    import mmio_pkg::*;
#(
    parameter int    Dbits      = 32,
    parameter int    Nout       = 4,
    parameter int    Nin        = 2,
    parameter int    KQ_DEPTH   = 8,
    parameter int    DMEM_WORDS = 64,
    parameter int    SMEM_WORDS = 1200,
    parameter int    SMEM_BITS  = 4,
    parameter int    VGA_ABITS  = 11,
    parameter string dmem_init  = "dmem_full-IO-test.mem",
    parameter string smem_init  = "smem_screentest.mem"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_wr,
    input  logic                  cpu_rd,
    input  logic [Dbits-1:0]      cpu_addr,
    input  logic [Dbits-1:0]      cpu_writedata,
    output logic [Dbits-1:0]      cpu_readdata,
    input  logic                  key_valid,
    input  logic [7:0]            key_char,
    input  logic [Nin*32-1:0]     in_val,
    output logic [Nout*32-1:0]    out_val,
    output logic [Nout-1:0]       out_wr,
    input  logic [VGA_ABITS-1:0]  vga_addr,
    output logic [SMEM_BITS-1:0]  vga_readdata
);
    localparam int DAW = $clog2(DMEM_WORDS);
    localparam int SAW = $clog2(SMEM_WORDS);
    localparam int KCW = $clog2(KQ_DEPTH) + 1;

    region_t               region;
    wmode_t                mode;
    logic [31:0]           widx;
    logic                  io_sel;
    logic [Dbits-1:0]      dmem_rd;
    logic [SMEM_BITS-1:0]  smem_rd;
    logic [7:0]            key_head;
    logic [KCW-1:0]        key_cnt;
    logic                  key_full, key_empty, key_ovf;
    logic [31:0]           keystat;
    logic [Nout-1:0][31:0] out_q, out_d;
    logic [Nout-1:0]       out_wr_q, out_wr_d;
    logic                  unused_bits;

    assign region = region_t'(cpu_addr[17:16]);
    assign mode   = wmode_t'(cpu_addr[9:8]);
    assign widx   = {26'd0, cpu_addr[7:2]};
    assign io_sel = (region == REG_IO);
    assign unused_bits = ^{cpu_addr[Dbits-1:18], cpu_addr[15:13], cpu_addr[1:0]};

    key_fifo #(.DEPTH(KQ_DEPTH)) u_kq (
        .clk       (clk),
        .reset     (reset),
        .push_i    (key_valid),
        .data_i    (key_char),
        .pop_i     (cpu_rd && io_sel && widx == IO_KEYDATA),
        .ovf_clr_i (cpu_wr && io_sel && widx == IO_KEYSTAT),
        .head_o    (key_head),
        .count_o   (key_cnt),
        .full_o    (key_full),
        .empty_o   (key_empty),
        .ovf_o     (key_ovf)
    );

    dmem #(.Nloc(DMEM_WORDS), .Dbits(Dbits)) u_dmem (
        .clk  (clk),
        .wr   (cpu_wr && region == REG_DMEM),
        .addr (cpu_addr[2 +: DAW]),
        .din  (cpu_writedata),
        .dout (dmem_rd)
    );

    screenmem #(.Nloc(SMEM_WORDS), .Dbits(SMEM_BITS), .VA(VGA_ABITS)) u_smem (
        .clk   (clk),
        .wr    (cpu_wr && region == REG_SMEM),
        .addr  (cpu_addr[2 +: SAW]),
        .din   (cpu_writedata[SMEM_BITS-1:0]),
        .dout  (smem_rd),
        .vaddr (vga_addr),
        .vdout (vga_readdata)
    );

    // KEYSTAT word assembly; count above 255 does not fit the byte field.
    always_comb begin
        keystat = '0;
        keystat[KS_EMPTY] = key_empty;
        keystat[KS_FULL]  = key_full;
        keystat[KS_OVF]   = key_ovf;
        keystat[KS_CNT_LSB +: 8] = 8'(key_cnt);
    end

    // Next output-register values and one-hot write strobe for this cycle.
    always_comb begin
        out_d    = out_q;
        out_wr_d = '0;
        if (cpu_wr && io_sel) begin
            for (int i = 0; i < Nout; i++) begin
                if (widx == IO_OUT_BASE + i) begin
                    out_d[i]    = apply_mode(mode, out_q[i], cpu_writedata[31:0]);
                    out_wr_d[i] = 1'b1;
                end
            end
        end
    end

    // Output registers and strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q    <= '0;
            out_wr_q <= '0;
        end else begin
            out_q    <= out_d;
            out_wr_q <= out_wr_d;
        end
    end

    assign out_val = out_q;
    assign out_wr  = out_wr_q;

    // Zero-latency read data mux.
    always_comb begin
        cpu_readdata = '0;
        case (region)
            REG_DMEM: cpu_readdata = dmem_rd;
            REG_SMEM: cpu_readdata = Dbits'(smem_rd);
            REG_IO: begin
                if (widx == IO_KEYDATA) cpu_readdata = Dbits'(key_head);
                if (widx == IO_KEYSTAT) cpu_readdata = Dbits'(keystat);
                for (int k = 0; k < Nin; k++)
                    if (widx == IO_IN_BASE + k) cpu_readdata = Dbits'(in_val[32*k +: 32]);
                for (int i = 0; i < Nout; i++)
                    if (widx == IO_OUT_BASE + i) cpu_readdata = Dbits'(out_q[i]);
            end
            default: ;
        endcase
    end

endmodule
